// File: rtl/ascii_text_console_pkg.sv
// Shared constants, state encoding and address helper for the 80x60 text console.
package ascii_console_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 13;

  localparam logic [23:0] BLANK_RGB   = 24'hFFFFFF;
  localparam logic [7:0]  ASCII_LF    = 8'h0A;
  localparam logic [7:0]  ASCII_CR    = 8'h0D;
  localparam logic [7:0]  ASCII_BS    = 8'h08;
  localparam logic [7:0]  ASCII_FF    = 8'h0C;
  localparam logic [7:0]  ASCII_SPACE = 8'h20;
  localparam logic [31:0] BLANK_CELL  = {ASCII_SPACE, BLANK_RGB};

  localparam logic [ADDR_W-1:0] CELLS_LAST = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] COLS_LAST  = ADDR_W'(COLS - 1);

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;

  // row*80 as (row<<6)+(row<<4): two adders instead of a multiplier
  function automatic logic [ADDR_W-1:0] row_base(input logic [5:0] r);
    logic [ADDR_W-1:0] rz;
    rz = {{(ADDR_W-6){1'b0}}, r};
    return (rz << 6) + (rz << 4);
  endfunction

endpackage

// File: rtl/ascii_text_console_if.sv
// Byte-stream handshake plus cell-write port of the text console.
interface ascii_text_console_if;
  import ascii_console_pkg::*;

  logic              char_valid;
  logic [7:0]        char_data;
  logic [23:0]       char_rgb;
  logic              char_ready;
  logic              ascii_write_en;
  logic [ADDR_W-1:0] ascii_write_address;
  logic [31:0]       ascii_input;
  logic [6:0]        cursor_col;
  logic [5:0]        cursor_row;
  logic              busy;

  modport master (
    output char_valid, char_data, char_rgb,
    input  char_ready, ascii_write_en, ascii_write_address, ascii_input,
           cursor_col, cursor_row, busy
  );

  modport slave (
    input  char_valid, char_data, char_rgb,
    output char_ready, ascii_write_en, ascii_write_address, ascii_input,
           cursor_col, cursor_row, busy
  );

endinterface

// File: rtl/ascii_text_console.sv
// Text console: turns an ASCII byte stream into cell writes on an 80x60 wrapping screen,
// clearing the whole screen after reset/FF and each line as the cursor enters it.
module ascii_text_console
  import ascii_console_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ascii_text_console_if.slave bus
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [6:0]        col, col_nxt;
  logic [5:0]        row, row_nxt, row_adv;
  logic              wr_en, wr_en_nxt;
  logic              clr_wr, clr_wr_nxt;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
  logic [31:0]       wr_data, wr_data_nxt;
  logic [ADDR_W-1:0] cur_base;
  logic              ready, accept;
  logic              is_print, is_lf, is_cr, is_bs, is_ff;
  logic              last_col, last_row, wrap;
  logic [7:0]        ch;

  // Ready stays low while the final clear write is still on the port.
  assign ready    = (state == IDLE) && !clr_wr;
  assign accept   = bus.char_valid && ready;
  assign ch       = bus.char_data;
  assign is_print = (ch >= 8'h20) && (ch <= 8'h7E);
  assign is_lf    = (ch == ASCII_LF);
  assign is_cr    = (ch == ASCII_CR);
  assign is_bs    = (ch == ASCII_BS);
  assign is_ff    = (ch == ASCII_FF);
  assign last_col = (col == 7'(COLS - 1));
  assign last_row = (row == 6'(ROWS - 1));
  assign row_adv  = last_row ? 6'd0 : row + 6'd1;
  assign wrap     = (is_print && last_col) || is_lf;
  assign cur_base = row_base(row);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CLR_ALL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLR_ALL:  if (clr_cnt == CELLS_LAST) state_nxt = IDLE;
      CLR_LINE: if (clr_cnt == COLS_LAST)  state_nxt = IDLE;
      IDLE: begin
        if (accept) begin
          if (is_ff)     state_nxt = CLR_ALL;
          else if (wrap) state_nxt = CLR_LINE;
        end
      end
      default: state_nxt = CLR_ALL;
    endcase
  end

  always_comb begin
    col_nxt     = col;
    row_nxt     = row;
    clr_cnt_nxt = clr_cnt;
    wr_en_nxt   = 1'b0;
    clr_wr_nxt  = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    case (state)
      CLR_ALL: begin
        wr_en_nxt   = 1'b1;
        clr_wr_nxt  = 1'b1;
        wr_addr_nxt = clr_cnt;
        wr_data_nxt = BLANK_CELL;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == CELLS_LAST) begin
          clr_cnt_nxt = '0;
          col_nxt     = '0;
          row_nxt     = '0;
        end
      end
      CLR_LINE: begin
        wr_en_nxt   = 1'b1;
        clr_wr_nxt  = 1'b1;
        wr_addr_nxt = cur_base + clr_cnt;
        wr_data_nxt = BLANK_CELL;
        clr_cnt_nxt = (clr_cnt == COLS_LAST) ? '0 : clr_cnt + 1'b1;
      end
      IDLE: begin
        if (accept) begin
          if (is_print) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = cur_base + {6'd0, col};
            wr_data_nxt = {ch, bus.char_rgb};
            if (!last_col) begin
              col_nxt = col + 7'd1;
            end else begin
              col_nxt     = '0;
              row_nxt     = row_adv;
              clr_cnt_nxt = '0;
            end
          end else if (is_lf) begin
            col_nxt     = '0;
            row_nxt     = row_adv;
            clr_cnt_nxt = '0;
          end else if (is_cr) begin
            col_nxt = '0;
          end else if (is_bs) begin
            if (col != 7'd0) begin
              col_nxt     = col - 7'd1;
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = cur_base + {6'd0, col - 7'd1};
              wr_data_nxt = BLANK_CELL;
            end
          end else if (is_ff) begin
            clr_cnt_nxt = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered cell-write port and cursor
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_cnt <= '0;
      col     <= '0;
      row     <= '0;
      wr_en   <= 1'b0;
      clr_wr  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      clr_cnt <= clr_cnt_nxt;
      col     <= col_nxt;
      row     <= row_nxt;
      wr_en   <= wr_en_nxt;
      clr_wr  <= clr_wr_nxt;
      wr_addr <= wr_addr_nxt;
      wr_data <= wr_data_nxt;
    end
  end

  assign bus.char_ready          = ready;
  assign bus.busy                = ~ready;
  assign bus.ascii_write_en      = wr_en;
  assign bus.ascii_write_address = wr_addr;
  assign bus.ascii_input         = wr_data;
  assign bus.cursor_col          = col;
  assign bus.cursor_row          = row;

endmodule

// File: tb/tb_ascii_text_console.sv
// Randomized scoreboard bench for ascii_text_console with a screen-level reference model.
module tb_ascii_text_console;

  localparam int NCOL  = 80;
  localparam int NROW  = 60;
  localparam int NCELL = NCOL * NROW;
  localparam logic [31:0] BLANK = 32'h20FFFFFF;
  localparam int LIM = 10000;

  typedef struct {
    logic [12:0] addr;
    logic [31:0] data;
    bit          clr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ascii_text_console_if bus();

  ascii_text_console dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   mcol  = 0;
  int   mrow  = 0;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic abort(input string name);
    bad++;
    total++;
    $display("FAIL %s timeout", name);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench aborted");
  endtask

  function automatic void push_w(input int a, input logic [31:0] d, input bit c);
    exp_t e;
    e.addr = 13'(a);
    e.data = d;
    e.clr  = c;
    q.push_back(e);
  endfunction

  function automatic void push_full_clear();
    for (int a = 0; a < NCELL; a++) push_w(a, BLANK, 1'b1);
  endfunction

  function automatic void adv_row();
    mrow = (mrow + 1) % NROW;
    for (int c = 0; c < NCOL; c++) push_w(mrow * NCOL + c, BLANK, 1'b1);
  endfunction

  // Screen-level behaviour of one accepted byte
  function automatic void model(input logic [7:0] ch, input logic [23:0] rgb);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      push_w(mrow * NCOL + mcol, {ch, rgb}, 1'b0);
      mcol++;
      if (mcol == NCOL) begin
        mcol = 0;
        adv_row();
      end
    end else if (ch == 8'h0A) begin
      mcol = 0;
      adv_row();
    end else if (ch == 8'h0D) begin
      mcol = 0;
    end else if (ch == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        push_w(mrow * NCOL + mcol, BLANK, 1'b0);
      end
    end else if (ch == 8'h0C) begin
      push_full_clear();
      mcol = 0;
      mrow = 0;
    end
  endfunction

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] v;
    r = $urandom_range(0, 99);
    if (r < 60) return 8'($urandom_range(32, 126));
    if (r < 68) return 8'h0A;
    if (r < 74) return 8'h0D;
    if (r < 84) return 8'h08;
    v = 8'($urandom_range(0, 255));
    while ((v >= 8'h20 && v <= 8'h7E) || v == 8'h0A || v == 8'h0D || v == 8'h08 || v == 8'h0C)
      v = 8'($urandom_range(0, 255));
    return v;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.ascii_write_en === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_write_addr", 32'(bus.ascii_write_address), 32'h1FFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("write_addr", 32'(bus.ascii_write_address), 32'(e.addr));
        chk("write_data", bus.ascii_input, e.data);
        if (e.clr) chk("ready_during_clear", 32'(bus.char_ready), 32'd0);
      end
    end
  end

  task automatic check_cursor(input string name);
    chk({name, "_col"}, 32'(bus.cursor_col), 32'(mcol));
    chk({name, "_row"}, 32'(bus.cursor_row), 32'(mrow));
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
  task automatic send(input logic [7:0] ch, input logic [23:0] rgb, input bit chk_cur);
    int n;
    bus.char_valid = 1'b1;
    bus.char_data  = ch;
    bus.char_rgb   = rgb;
    n = 0;
    @(negedge clk);
    while (bus.char_ready !== 1'b1 && n < LIM) begin
      n++;
      @(negedge clk);
    end
    if (bus.char_ready !== 1'b1) abort("send_wait_ready");
    model(ch, rgb);
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    if (chk_cur) check_cursor("cursor");
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.char_ready !== 1'b1 && n < LIM) begin
      n++;
      @(negedge clk);
    end
    if (bus.char_ready !== 1'b1) abort("wait_ready");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [23:0] zrgb;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.char_rgb   = 24'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_write_en", 32'(bus.ascii_write_en), 32'd0);
    chk("reset_addr", 32'(bus.ascii_write_address), 32'd0);
    chk("reset_data", bus.ascii_input, 32'd0);
    chk("reset_cursor_col", 32'(bus.cursor_col), 32'd0);
    chk("reset_cursor_row", 32'(bus.cursor_row), 32'd0);
    chk("reset_ready", 32'(bus.char_ready), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd1);

    // Power-up clear
    push_full_clear();
    rst = 1'b1;
    wait_ready();
    chk("initial_clear_done", 32'(q.size()), 32'd0);
    check_cursor("after_init");

    // Single printable char
    send(8'h41, 24'h00FF00, 1'b1);
    chk("A_write_en", 32'(bus.ascii_write_en), 32'd1);
    chk("A_addr", 32'(bus.ascii_write_address), 32'd0);
    chk("A_data", bus.ascii_input, 32'h4100FF00);
    chk("A_col", 32'(bus.cursor_col), 32'd1);

    // Move to (2,5), then LF
    send(8'h0A, 24'h0, 1'b1);
    send(8'h0A, 24'h0, 1'b1);
    for (int i = 0; i < 5; i++) send(8'(8'h61 + i), 24'($urandom), 1'b1);
    chk("pos25_row", 32'(bus.cursor_row), 32'd2);
    chk("pos25_col", 32'(bus.cursor_col), 32'd5);
    send(8'h0A, 24'h0, 1'b1);
    chk("lf_row", 32'(bus.cursor_row), 32'd3);
    chk("lf_col", 32'(bus.cursor_col), 32'd0);
    n = 0;
    @(negedge clk);
    while (bus.char_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("lf_ready_low_cycles", 32'(n), 32'd81);
    @(posedge clk);
    #1;

    // Bottom-right corner wrap
    while (mrow != NROW - 1) send(8'h0A, 24'h0, 1'b0);
    while (mcol != NCOL - 1) send(8'($urandom_range(32, 126)), 24'($urandom), 1'b0);
    chk("corner_row", 32'(bus.cursor_row), 32'd59);
    chk("corner_col", 32'(bus.cursor_col), 32'd79);
    zrgb = 24'($urandom);
    send(8'h5A, zrgb, 1'b1);
    chk("Z_write_en", 32'(bus.ascii_write_en), 32'd1);
    chk("Z_addr", 32'(bus.ascii_write_address), 32'd4799);
    chk("Z_data", bus.ascii_input, {8'h5A, zrgb});
    chk("Z_row", 32'(bus.cursor_row), 32'd0);
    chk("Z_col", 32'(bus.cursor_col), 32'd0);
    wait_ready();

    // Backspace at column 0 and mid-line
    send(8'h0A, 24'h0, 1'b1);
    send(8'h08, 24'h0, 1'b1);
    chk("bs0_write_en", 32'(bus.ascii_write_en), 32'd0);
    chk("bs0_col", 32'(bus.cursor_col), 32'd0);
    chk("bs0_row", 32'(bus.cursor_row), 32'd1);
    send(8'h78, 24'h123456, 1'b1);
    send(8'h79, 24'h123456, 1'b1);
    send(8'h7A, 24'h123456, 1'b1);
    send(8'h08, 24'h0, 1'b1);
    chk("bs_write_en", 32'(bus.ascii_write_en), 32'd1);
    chk("bs_addr", 32'(bus.ascii_write_address), 32'd82);
    chk("bs_data", bus.ascii_input, 32'h20FFFFFF);
    chk("bs_col", 32'(bus.cursor_col), 32'd2);

    // Random stream
    for (int i = 0; i < 300; i++) send(rand_byte(), 24'($urandom), 1'b1);
    wait_ready();

    // Form feed, reset in the middle of the clear
    send(8'h0C, 24'h0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!(bus.ascii_write_en === 1'b1 && bus.ascii_write_address == 13'd1000) && n < LIM) begin
      n++;
      @(negedge clk);
    end
    if (n >= LIM) abort("ff_reach_1000");
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("midreset_write_en", 32'(bus.ascii_write_en), 32'd0);
      chk("midreset_ready", 32'(bus.char_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    mcol = 0;
    mrow = 0;
    push_full_clear();
    rst = 1'b1;
    wait_ready();
    chk("restart_clear_done", 32'(q.size()), 32'd0);
    check_cursor("after_restart");

    send(8'h42, 24'hABCDEF, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
